// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and helpers for the pipeline stall/flush controller.
// Included by pipe_hazard_ctrl and md_busy_cnt.
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] TUSE_NONE       = 2'd3;
    localparam int         MULT_CYCLES_DEF = 5;
    localparam int         DIV_CYCLES_DEF  = 10;
    localparam logic [4:0] EPC_REG         = 5'd14;

    typedef enum logic [1:0] {
        CTRL_RUN,
        CTRL_STALL,
        CTRL_FLUSH
    } ctrl_mode_e;

    // A consumer must wait when it reads a live producer result before that result exists.
    function automatic logic reg_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] wa,
        input logic [1:0] tnew
    );
        return (src != 5'd0) && (src == wa) && (tuse != TUSE_NONE) && (tuse < tnew);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_cnt.sv
// Multiply/divide busy countdown: loads on an accepted md start in E and
// counts to zero, even across an exception flush.
module md_busy_cnt
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic is_div,
    input  logic req,
    output logic busy
);

    logic [CNT_W-1:0] md_cnt;

    // A start arriving while the count is non-zero is ignored; the md stall keeps it from happening.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_cnt <= '0;
        end else if (start && !req && (md_cnt == '0)) begin
            md_cnt <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - 1'b1;
        end
    end

    assign busy = (md_cnt != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Optional stall statistics counters: define PIPE_HAZARD_CTRL_STAT_EN.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_rs_tuse,
    input  logic [1:0] D_rt_tuse,
    input  logic [4:0] E_wa,
    input  logic [1:0] E_tnew,
    input  logic [4:0] M_wa,
    input  logic [1:0] M_tnew,
    input  logic       D_is_md,
    input  logic       E_md_start,
    input  logic       E_md_div,
    input  logic       D_eret,
    input  logic       E_mtc0_epc,
    input  logic       M_mtc0_epc,
    input  logic       Req,
    output logic       F_WE,
    output logic       D_WE,
    output logic       E_clr,
    output logic       pipe_req,
    output logic       md_busy,
    output logic       stall
`ifdef PIPE_HAZARD_CTRL_STAT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] md_stall_cnt
`endif
);

    logic       data_stall;
    logic       md_stall;
    logic       eret_stall;
    ctrl_mode_e mode;

    md_busy_cnt #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_cnt (
        .clk    (clk),
        .rst    (rst),
        .start  (E_md_start),
        .is_div (E_md_div),
        .req    (Req),
        .busy   (md_busy)
    );

    always_comb begin
        data_stall = reg_hazard(D_rs, D_rs_tuse, E_wa, E_tnew)
                   | reg_hazard(D_rt, D_rt_tuse, E_wa, E_tnew)
                   | reg_hazard(D_rs, D_rs_tuse, M_wa, M_tnew)
                   | reg_hazard(D_rt, D_rt_tuse, M_wa, M_tnew);
        md_stall   = D_is_md & (md_busy | E_md_start);
        eret_stall = D_eret & (E_mtc0_epc | M_mtc0_epc);
        stall      = data_stall | md_stall | eret_stall;
    end

    // An exception flush overrides any stall; the flushed registers clear themselves.
    always_comb begin
        if (Req) begin
            mode = CTRL_FLUSH;
        end else if (stall) begin
            mode = CTRL_STALL;
        end else begin
            mode = CTRL_RUN;
        end
    end

    always_comb begin
        F_WE     = 1'b1;
        D_WE     = 1'b1;
        E_clr    = 1'b0;
        pipe_req = 1'b0;
        case (mode)
            CTRL_FLUSH: pipe_req = 1'b1;
            CTRL_STALL: begin
                F_WE  = 1'b0;
                D_WE  = 1'b0;
                E_clr = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef PIPE_HAZARD_CTRL_STAT_EN
    // Saturating counts of cycles actually lost to stalls (flush cycles excluded).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt    <= '0;
            md_stall_cnt <= '0;
        end else begin
            if (stall && !Req && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (md_stall && !Req && (md_stall_cnt != 32'hFFFF_FFFF)) begin
                md_stall_cnt <= md_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a cycle-level model checked on every
// negedge plus directed scenarios with literal expectations.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic [4:0] D_rs;
        logic [4:0] D_rt;
        logic [1:0] D_rs_tuse;
        logic [1:0] D_rt_tuse;
        logic [4:0] E_wa;
        logic [1:0] E_tnew;
        logic [4:0] M_wa;
        logic [1:0] M_tnew;
        logic       D_is_md;
        logic       E_md_start;
        logic       E_md_div;
        logic       D_eret;
        logic       E_mtc0_epc;
        logic       M_mtc0_epc;
        logic       Req;
    } stim_t;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] D_rs, D_rt, E_wa, M_wa;
    logic [1:0] D_rs_tuse, D_rt_tuse, E_tnew, M_tnew;
    logic       D_is_md, E_md_start, E_md_div, D_eret, E_mtc0_epc, M_mtc0_epc, Req;
    logic       F_WE, D_WE, E_clr, pipe_req, md_busy, stall;
`ifdef PIPE_HAZARD_CTRL_STAT_EN
    logic [31:0] stall_cnt, md_stall_cnt;
    logic [31:0] statStall, statMd;
`endif

    int testsRun = 0;
    int testsFailed = 0;
    int edgeCount = 0;
    int mdEnd = 0;
    int busyCount;
    stim_t s;

    pipe_hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .D_rs       (D_rs),
        .D_rt       (D_rt),
        .D_rs_tuse  (D_rs_tuse),
        .D_rt_tuse  (D_rt_tuse),
        .E_wa       (E_wa),
        .E_tnew     (E_tnew),
        .M_wa       (M_wa),
        .M_tnew     (M_tnew),
        .D_is_md    (D_is_md),
        .E_md_start (E_md_start),
        .E_md_div   (E_md_div),
        .D_eret     (D_eret),
        .E_mtc0_epc (E_mtc0_epc),
        .M_mtc0_epc (M_mtc0_epc),
        .Req        (Req),
        .F_WE       (F_WE),
        .D_WE       (D_WE),
        .E_clr      (E_clr),
        .pipe_req   (pipe_req),
        .md_busy    (md_busy),
        .stall      (stall)
`ifdef PIPE_HAZARD_CTRL_STAT_EN
        ,
        .stall_cnt    (stall_cnt),
        .md_stall_cnt (md_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // The md unit is busy from the edge that accepts a start until N edges later.
    function automatic logic modelBusy();
        return edgeCount < mdEnd;
    endfunction

    function automatic logic modelMdStall();
        return D_is_md && (modelBusy() || E_md_start);
    endfunction

    function automatic logic modelStall();
        logic [4:0] srcReg [2];
        logic [1:0] srcUse [2];
        logic [4:0] dstReg [2];
        logic [1:0] dstNew [2];
        logic       hit;
        srcReg[0] = D_rs; srcUse[0] = D_rs_tuse;
        srcReg[1] = D_rt; srcUse[1] = D_rt_tuse;
        dstReg[0] = E_wa; dstNew[0] = E_tnew;
        dstReg[1] = M_wa; dstNew[1] = M_tnew;
        hit = 1'b0;
        for (int c = 0; c < 2; c++)
            for (int p = 0; p < 2; p++)
                if (srcReg[c] != 0 && srcReg[c] == dstReg[p] && int'(srcUse[c]) < int'(dstNew[p]))
                    hit = 1'b1;
        return hit || modelMdStall() || (D_eret && (E_mtc0_epc || M_mtc0_epc));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdEnd <= 0;
`ifdef PIPE_HAZARD_CTRL_STAT_EN
            statStall <= 32'd0;
            statMd    <= 32'd0;
`endif
        end else begin
            edgeCount <= edgeCount + 1;
            if (E_md_start && !Req && !modelBusy())
                mdEnd <= edgeCount + 1 + (E_md_div ? DIV_N : MULT_N);
`ifdef PIPE_HAZARD_CTRL_STAT_EN
            if (modelStall() && !Req && statStall != 32'hFFFF_FFFF) statStall <= statStall + 1;
            if (modelMdStall() && !Req && statMd != 32'hFFFF_FFFF) statMd <= statMd + 1;
`endif
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Every cycle, all outputs must follow the model's stall/flush decision.
    always @(negedge clk) begin
        logic st;
        st = modelStall();
        checkOutput("cyc stall",    32'(stall),    32'(st));
        checkOutput("cyc F_WE",     32'(F_WE),     32'(Req || !st));
        checkOutput("cyc D_WE",     32'(D_WE),     32'(Req || !st));
        checkOutput("cyc E_clr",    32'(E_clr),    32'(!Req && st));
        checkOutput("cyc pipe_req", 32'(pipe_req), 32'(Req));
        checkOutput("cyc md_busy",  32'(md_busy),  32'(modelBusy()));
`ifdef PIPE_HAZARD_CTRL_STAT_EN
        checkOutput("cyc stall_cnt",    stall_cnt,    statStall);
        checkOutput("cyc md_stall_cnt", md_stall_cnt, statMd);
`endif
    end

    function automatic stim_t idleStim();
        stim_t v;
        v = '0;
        v.D_rs_tuse = 2'd3;
        v.D_rt_tuse = 2'd3;
        return v;
    endfunction

    task automatic applyStimulus(input stim_t v);
        @(posedge clk);
        #1;
        D_rs = v.D_rs; D_rt = v.D_rt; D_rs_tuse = v.D_rs_tuse; D_rt_tuse = v.D_rt_tuse;
        E_wa = v.E_wa; E_tnew = v.E_tnew; M_wa = v.M_wa; M_tnew = v.M_tnew;
        D_is_md = v.D_is_md; E_md_start = v.E_md_start; E_md_div = v.E_md_div;
        D_eret = v.D_eret; E_mtc0_epc = v.E_mtc0_epc; M_mtc0_epc = v.M_mtc0_epc; Req = v.Req;
        @(negedge clk);
    endtask

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        s = idleStim();
        {D_rs, D_rt, E_wa, M_wa} = '0;
        {D_rs_tuse, D_rt_tuse} = 4'hF;
        {E_tnew, M_tnew} = '0;
        {D_is_md, E_md_start, E_md_div, D_eret, E_mtc0_epc, M_mtc0_epc, Req} = '0;
        @(negedge clk);
        checkOutput("reset md_busy", 32'(md_busy), 32'd0);
        checkOutput("reset F_WE", 32'(F_WE), 32'd1);
        checkOutput("reset stall", 32'(stall), 32'd0);
`ifdef PIPE_HAZARD_CTRL_STAT_EN
        checkOutput("reset stall_cnt", stall_cnt, 32'd0);
`endif
        #2 rst = 1'b0;

        // Load-use: result two cycles out, then one cycle out from M, then ready.
        s = idleStim(); s.E_wa = 5'd8; s.E_tnew = 2'd2; s.D_rs = 5'd8; s.D_rs_tuse = 2'd0;
        applyStimulus(s);
        checkOutput("loaduse stall", 32'(stall), 32'd1);
        checkOutput("loaduse F_WE", 32'(F_WE), 32'd0);
        checkOutput("loaduse D_WE", 32'(D_WE), 32'd0);
        checkOutput("loaduse E_clr", 32'(E_clr), 32'd1);
        s.E_wa = 5'd0; s.E_tnew = 2'd1; s.M_wa = 5'd8; s.M_tnew = 2'd1;
        applyStimulus(s);
        checkOutput("loaduse M stall", 32'(stall), 32'd1);
        s.M_wa = 5'd0; s.M_tnew = 2'd0;
        applyStimulus(s);
        checkOutput("loaduse clear", 32'(stall), 32'd0);

        // Register 0 never hazards; tuse == tnew is ready in time; tuse 3 means unused.
        s = idleStim(); s.E_wa = 5'd0; s.E_tnew = 2'd2; s.D_rs = 5'd0; s.D_rs_tuse = 2'd0;
        applyStimulus(s);
        checkOutput("zero reg", 32'(stall), 32'd0);
        s = idleStim(); s.D_rt = 5'd5; s.D_rt_tuse = 2'd1; s.M_wa = 5'd5; s.M_tnew = 2'd1;
        applyStimulus(s);
        checkOutput("rt tuse==tnew", 32'(stall), 32'd0);
        s.D_rt_tuse = 2'd0;
        applyStimulus(s);
        checkOutput("rt tuse<tnew", 32'(stall), 32'd1);
        s = idleStim(); s.D_rs = 5'd9; s.E_wa = 5'd9; s.E_tnew = 2'd2;
        applyStimulus(s);
        checkOutput("tuse none", 32'(stall), 32'd0);

        // mult followed by an md instruction in D.
        s = idleStim(); s.E_md_start = 1'b1; s.E_md_div = 1'b0; s.D_is_md = 1'b1;
        applyStimulus(s);
        checkOutput("mult start stall", 32'(stall), 32'd1);
        checkOutput("mult start D_WE", 32'(D_WE), 32'd0);
        s = idleStim(); s.D_is_md = 1'b1;
        busyCount = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(s);
            if (!md_busy) begin
                checkOutput("mult release D_WE", 32'(D_WE), 32'd1);
                break;
            end
            busyCount++;
        end
        checkOutput("mult busy cycles", 32'(busyCount), 32'd5);

        // div interrupted by Req on its third busy cycle; the countdown still completes.
        s = idleStim(); s.E_md_start = 1'b1; s.E_md_div = 1'b1;
        applyStimulus(s);
        checkOutput("div start busy", 32'(md_busy), 32'd0);
        busyCount = 0;
        for (int i = 0; i < 30; i++) begin
            s = idleStim(); s.Req = (i == 2); s.D_is_md = (i == 2);
            applyStimulus(s);
            if (i == 2) begin
                checkOutput("req pipe_req", 32'(pipe_req), 32'd1);
                checkOutput("req F_WE", 32'(F_WE), 32'd1);
                checkOutput("req D_WE", 32'(D_WE), 32'd1);
                checkOutput("req E_clr", 32'(E_clr), 32'd0);
            end
            if (!md_busy) break;
            busyCount++;
        end
        checkOutput("div busy cycles", 32'(busyCount), 32'd10);

        // Req on the start cycle suppresses the md load.
        s = idleStim(); s.E_md_start = 1'b1; s.Req = 1'b1;
        applyStimulus(s);
        checkOutput("req start pipe_req", 32'(pipe_req), 32'd1);
        applyStimulus(idleStim());
        checkOutput("req start busy", 32'(md_busy), 32'd0);

        // eret waits for an in-flight mtc0 EPC.
        s = idleStim(); s.D_eret = 1'b1; s.M_mtc0_epc = 1'b1;
        applyStimulus(s);
        checkOutput("eret M stall", 32'(stall), 32'd1);
        s.M_mtc0_epc = 1'b0;
        applyStimulus(s);
        checkOutput("eret clear", 32'(stall), 32'd0);
        s.E_mtc0_epc = 1'b1;
        applyStimulus(s);
        checkOutput("eret E stall", 32'(stall), 32'd1);

        // Async reset with the div countdown at 6.
        s = idleStim(); s.E_md_start = 1'b1; s.E_md_div = 1'b1;
        applyStimulus(s);
        for (int i = 0; i < 5; i++) applyStimulus(idleStim());
        checkOutput("mid div busy", 32'(md_busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async reset busy", 32'(md_busy), 32'd0);
`ifdef PIPE_HAZARD_CTRL_STAT_EN
        checkOutput("async reset stall_cnt", stall_cnt, 32'd0);
        checkOutput("async reset md_stall_cnt", md_stall_cnt, 32'd0);
`endif
        #1 rst = 1'b0;
        applyStimulus(idleStim());
        checkOutput("post reset busy", 32'(md_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline. Drives write enables and clears for the F/D/E/M/W pipeline registers.
- Detects Tuse/Tnew data hazards, HI/LO multiply-divide busy hazards and eret-vs-mtc0 EPC hazards.
- Owns the multiply/divide busy countdown.
- Forwards the CP0 exception request (Req) as a pipeline-wide flush with priority over every stall.

Parameters:
- MULT_CYCLES, 5, busy cycles after mult/multu start in E.
- DIV_CYCLES, 10, busy cycles after div/divu start in E.
- CNT_W, 4, md countdown width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- D_rs  input  5  rs register index of the D-stage instruction.
- D_rt  input  5  rt register index of the D-stage instruction.
- D_rs_tuse  input  2  cycles until D needs rs; 3 = not used.
- D_rt_tuse  input  2  cycles until D needs rt; 3 = not used.
- E_wa  input  5  E-stage destination register; 0 = none.
- E_tnew  input  2  cycles until the E result is ready.
- M_wa  input  5  M-stage destination register; 0 = none.
- M_tnew  input  2  cycles until the M result is ready.
- D_is_md  input  1  D instruction uses the md unit (mult/div/mfhi/mflo/mthi/mtlo).
- E_md_start  input  1  E holds mult/multu/div/divu.
- E_md_div  input  1  qualifies E_md_start: 1 = divide, 0 = multiply.
- D_eret  input  1  D holds eret.
- E_mtc0_epc  input  1  E holds mtc0 to EPC (reg 14).
- M_mtc0_epc  input  1  M holds mtc0 to EPC.
- Req  input  1  exception/interrupt request from CP0.
- F_WE  output  1  PC/F-register enable.
- D_WE  output  1  D-register enable.
- E_clr  output  1  synchronous bubble insert into the E register.
- pipe_req  output  1  flush request to D/E/M/W registers.
- md_busy  output  1  md unit busy (registered count ≠ 0).
- stall  output  1  combined stall, for debug/trace.

Behaviour:
- Registered state:
  - md_cnt[CNT_W-1:0]; reset value 0.
  - md_busy = (md_cnt != 0); 0 during and after reset.
- Data stall:
  - For each of rs and rt: stall if reg ≠ 0 and reg == E_wa and tuse < E_tnew.
  - Likewise against M_wa / M_tnew.
- md stall: D_is_md & (md_busy | E_md_start).
- eret stall: D_eret & (E_mtc0_epc | M_mtc0_epc).
- Combined stall: stall = data | md | eret (all combinational, zero latency).
- Output decode:
  - Req = 1: F_WE = 1, D_WE = 1, E_clr = 0, pipe_req = 1. Stall is ignored; the pipeline registers self-clear on pipe_req.
  - else stall = 1: F_WE = 0, D_WE = 0, E_clr = 1, pipe_req = 0.
  - else: F_WE = 1, D_WE = 1, E_clr = 0, pipe_req = 0.
- md counter, evaluated per edge in priority order:
  - rst asserted (async): md_cnt = 0.
  - else E_md_start & !Req & md_cnt == 0: load DIV_CYCLES if E_md_div, else MULT_CYCLES.
  - else md_cnt ≠ 0: decrement by 1 (also while Req = 1; a committed md op finishes).
  - else hold 0.
- E_md_start with md_cnt ≠ 0 cannot happen, because the md stall prevents it. Verification flags it as an assertion failure and the counter ignores it.
- Back-to-back md ops: the second is held in D until md_cnt reaches 0 and the first has left E. Its start cycle is therefore the edge on which md_cnt returns to 0 or later.
- Reset mid-countdown: md_cnt clears immediately (async); md_busy drops without waiting for a clock.

Optional Feature:
- Macro PIPE_HAZARD_CTRL_STAT_EN.
- Defined:
  - Adds output stall_cnt[31:0], reset 0 (async).
  - Increments on each clock with stall & !Req; saturates at 32'hFFFF_FFFF.
  - Adds output md_stall_cnt[31:0] with the same rules, restricted to md stall.
- Undefined: both ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/defines header holds:
  - TUSE_NONE = 2'd3.
  - MULT_CYCLES and DIV_CYCLES default constants.
  - EPC register index 5'd14.
- One natural sub-module: md_busy_cnt, containing the countdown, the load logic and the busy flag.
- Hazard compare logic stays inline in pipe_hazard_ctrl.

Test Plan:
- Load-use: E_wa = 8, E_tnew = 2, D_rs = 8, D_rs_tuse = 0 → stall = 1, F_WE = D_WE = 0, E_clr = 1. Next cycle, E_tnew = 1 and M_wa = 8, M_tnew = 1 → stall stays 1 one more cycle, then 0.
- Zero register: E_wa = 0, E_tnew = 2, D_rs = 0, D_rs_tuse = 0 → stall = 0.
- mult then mfhi:
  - E_md_start = 1, E_md_div = 0, D_is_md = 1 → stall that cycle.
  - md_busy high for exactly 5 cycles.
  - D_WE returns to 1 on the cycle md_cnt reads 0.
- div with interrupt:
  - Start div; Req = 1 on the third busy cycle → pipe_req = 1, F_WE = 1, E_clr = 0.
  - md_cnt keeps counting down; md_busy totals 10 cycles.
- Req on the start cycle: E_md_start = 1 & Req = 1 → md_cnt stays 0 and md_busy = 0.
- eret hazard and async reset:
  - D_eret = 1 with M_mtc0_epc = 1 → stall = 1; clears once the mtc0 leaves M.
  - Assert rst mid-div with md_cnt = 6 → md_busy = 0 before the next clk edge.
  - With STAT_EN defined, stall_cnt reads 0 after reset.
